// File: rtl/xsip_board_summary_monitor.sv
// -----------------------------------------------------------------------------
// xsip_board_summary_monitor
//
// Consumer end of the board-level summary word. Every cycle with board_valid
// high, the summary fields are captured and compared with fixed thresholds.
// A debounced NORMAL/WARN/CRIT health FSM follows the result. Each health
// transition is logged into a small event FIFO that the XSIP management path
// drains.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   board_summary  256-bit summary word (field map below)
//   board_valid    sample qualifier, every high cycle is one sample
//   clr_overflow   clears the sticky evt_overflow flag
//   health_state   0=NORMAL 1=WARN 2=CRIT (this is the FSM state itself)
//   cause_now      cause bits of the most recent sample
//   evt_valid      event FIFO not empty
//   evt_data       head event {ts[31:0], cause[7:0], 2'b0, old[1:0], 2'b0, new[1:0]}
//   evt_ready      consumer ready
//   evt_overflow   sticky, set when an event had to be dropped
//
// Event handshake: an entry transfers on a cycle where evt_valid && evt_ready
// at the rising edge of clk. evt_valid is driven only by FIFO occupancy and
// never depends on evt_ready; evt_data is stable while evt_valid is high and
// not yet accepted (first-word fall-through; zero when empty).
//
// Field map: [255:232] power, [231:216] max_temp (unused), [215:208] grade,
// [207:176] vrm_eff, [167:160] pll lock byte, [159:128] osc_drift (signed),
// [127:112] air_flow, everything else ignored.
//
// Timing: a sample registered at edge N yields cause_now at edge N+1; the
// FSM/counter update and any FIFO push happen at edge N+2.
// -----------------------------------------------------------------------------
module xsip_board_summary_monitor #(
    parameter int unsigned DEBOUNCE    = 3,
    parameter logic [23:0] POWER_WARN  = 24'd40000,
    parameter logic [23:0] POWER_CRIT  = 24'd60000,
    parameter logic [31:0] DRIFT_LIMIT = 32'd1000,
    parameter logic [15:0] AIRFLOW_MIN = 16'd100,
    parameter logic [31:0] VRM_EFF_MIN = 32'd80,
    parameter logic [7:0]  LOCK_MASK   = 8'hFF,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] board_summary,
    input  logic         board_valid,
    input  logic         clr_overflow,
    output logic [1:0]   health_state,
    output logic [7:0]   cause_now,
    output logic         evt_valid,
    output logic [47:0]  evt_data,
    input  logic         evt_ready,
    output logic         evt_overflow
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        H_NORMAL = 2'd0,
        H_WARN   = 2'd1,
        H_CRIT   = 2'd2
    } health_t;

    // ---------------------------------------------------------------------
    // Stage 0: sample register (only the fields that are evaluated)
    // ---------------------------------------------------------------------
    logic        s0_valid;
    logic [23:0] s0_power;
    logic [7:0]  s0_grade;
    logic [31:0] s0_eff;
    logic [7:0]  s0_lock;
    logic [31:0] s0_drift;
    logic [15:0] s0_air;

    // Fields that carry no meaning for this monitor.
    logic unused_fields;
    assign unused_fields = ^{board_summary[231:216], board_summary[175:168],
                             board_summary[111:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_power <= '0;
            s0_grade <= '0;
            s0_eff   <= '0;
            s0_lock  <= '0;
            s0_drift <= '0;
            s0_air   <= '0;
        end else begin
            s0_valid <= board_valid;
            if (board_valid) begin
                s0_power <= board_summary[255:232];
                s0_grade <= board_summary[215:208];
                s0_eff   <= board_summary[207:176];
                s0_lock  <= board_summary[167:160];
                s0_drift <= board_summary[159:128];
                s0_air   <= board_summary[127:112];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Cause evaluation on the registered sample
    // ---------------------------------------------------------------------
    logic [32:0] drift_abs;
    logic [7:0]  cause_comb;
    health_t     tgt_comb;

    always_comb begin
        // 33-bit magnitude so that -2^31 becomes +2^31 rather than wrapping.
        drift_abs  = s0_drift[31] ? (33'd0 - {1'b1, s0_drift}) : {1'b0, s0_drift};
        cause_comb = '0;
        cause_comb[0] = (s0_grade >= 8'd2);
        cause_comb[1] = (s0_grade == 8'd3);
        cause_comb[2] = (s0_power > POWER_WARN);
        cause_comb[3] = (s0_power > POWER_CRIT);
        cause_comb[4] = (s0_lock != LOCK_MASK);
        cause_comb[5] = (drift_abs > {1'b0, DRIFT_LIMIT});
        cause_comb[6] = (s0_air < AIRFLOW_MIN);
        cause_comb[7] = (s0_eff < VRM_EFF_MIN);

        tgt_comb = H_NORMAL;
        if (|(cause_comb & 8'b0001_1010)) begin
            tgt_comb = H_CRIT;
        end else if (|(cause_comb & 8'b1110_0101)) begin
            tgt_comb = H_WARN;
        end
    end

    // ---------------------------------------------------------------------
    // Stage 1: cause_now / target register, held across board_valid gaps
    // ---------------------------------------------------------------------
    logic    s1_valid;
    health_t s1_tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_tgt    <= H_NORMAL;
            cause_now <= '0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_tgt    <= tgt_comb;
                cause_now <= cause_comb;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: debounced health FSM
    // ---------------------------------------------------------------------
    health_t          state;
    health_t          state_nxt;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] dn_cnt;
    logic [CNT_W-1:0] up_inc;
    logic [CNT_W-1:0] dn_inc;
    logic             esc;
    logic             desc;
    logic             esc_fire;
    logic             desc_fire;
    logic             evt_push;

    assign health_state = state;

    always_comb begin
        // Saturating increments; a fire always clears the counter, so the
        // saturation point is only a safety net.
        up_inc    = (up_cnt >= DEB_CNT) ? up_cnt : up_cnt + 1'b1;
        dn_inc    = (dn_cnt >= DEB_CNT) ? dn_cnt : dn_cnt + 1'b1;
        esc       = s1_valid && (s1_tgt > state);
        desc      = s1_valid && (s1_tgt < state);
        esc_fire  = esc  && (up_inc >= DEB_CNT);
        desc_fire = desc && (dn_inc >= DEB_CNT);
        evt_push  = esc_fire || desc_fire;

        state_nxt = state;
        if (esc_fire) begin
            state_nxt = s1_tgt;                      // escalation may skip WARN
        end else if (desc_fire) begin
            state_nxt = health_t'(state - 2'd1);     // recovery one level at a time
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= H_NORMAL;
            up_cnt <= '0;
            dn_cnt <= '0;
        end else if (s1_valid) begin
            if (esc) begin
                dn_cnt <= '0;
                up_cnt <= esc_fire ? '0 : up_inc;
            end else if (desc) begin
                up_cnt <= '0;
                dn_cnt <= desc_fire ? '0 : dn_inc;
            end else begin
                up_cnt <= '0;
                dn_cnt <= '0;
            end
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Free-running timestamp
    // ---------------------------------------------------------------------
    logic [31:0] ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + 32'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Event FIFO (extra pointer bit distinguishes full from empty)
    // ---------------------------------------------------------------------
    logic [47:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        evt_pop;
    logic        evt_wr;
    logic        evt_drop;
    logic [47:0] evt_word;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign evt_pop    = !fifo_empty && evt_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign evt_wr     = evt_push && (!fifo_full || evt_pop);
    assign evt_drop   = evt_push && fifo_full && !evt_pop;
    assign evt_word   = {ts, cause_now, 2'b00, state, 2'b00, state_nxt};

    assign evt_valid  = !fifo_empty;
    assign evt_data   = fifo_empty ? '0 : fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (evt_wr) begin
            fifo_mem[wr_ptr[AW-1:0]] <= evt_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (evt_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (evt_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A fresh drop wins over a coincident clear.
            if (evt_drop) begin
                evt_overflow <= 1'b1;
            end else if (clr_overflow) begin
                evt_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xsip_board_summary_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for xsip_board_summary_monitor: table of cause vectors, hand-built
// debounce/FIFO sequences, then randomized traffic checked every cycle against
// a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_xsip_board_summary_monitor;

  localparam int DEB   = 3;
  localparam int DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [255:0] board_summary = '0;
  logic         board_valid = 1'b0;
  logic         clr_overflow = 1'b0;
  logic         evt_ready = 1'b0;
  logic [1:0]   health_state;
  logic [7:0]   cause_now;
  logic         evt_valid;
  logic [47:0]  evt_data;
  logic         evt_overflow;

  always #5 clk = ~clk;

  xsip_board_summary_monitor dut (
    .clk(clk),
    .rst_n(rst_n),
    .board_summary(board_summary),
    .board_valid(board_valid),
    .clr_overflow(clr_overflow),
    .health_state(health_state),
    .cause_now(cause_now),
    .evt_valid(evt_valid),
    .evt_data(evt_data),
    .evt_ready(evt_ready),
    .evt_overflow(evt_overflow)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cap;     // edge number at which the sample was taken
    logic [7:0] cause;
    int         tgt;
  } smp_t;

  smp_t        smp_q[$];
  logic [47:0] exp_q[$];
  int          edge_no;
  int          m_state, m_up, m_dn;
  logic [7:0]  m_cause;
  logic        m_ovf;
  logic [31:0] m_ts;
  logic        rdy_mode;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] mk(input logic [23:0] p, input logic [7:0] g,
                                      input logic [31:0] e, input logic [7:0] l,
                                      input logic [31:0] d, input logic [15:0] a);
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[i*32 +: 32] = $urandom;
    s[255:232] = p;
    s[215:208] = g;
    s[207:176] = e;
    s[167:160] = l;
    s[159:128] = d;
    s[127:112] = a;
    return s;
  endfunction

  function automatic logic [255:0] clean();
    return mk(24'd1000, 8'd0, 32'd90, 8'hFF, 32'd0, 16'd200);
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] cause_of(input logic [255:0] s);
    logic [7:0] c;
    longint     dv;
    int         grade;
    grade = int'(s[215:208]);
    dv = longint'($signed(s[159:128]));
    if (dv < 0) dv = -dv;
    c[0] = grade >= 2;
    c[1] = grade == 3;
    c[2] = int'(s[255:232]) > 40000;
    c[3] = int'(s[255:232]) > 60000;
    c[4] = s[167:160] != 8'hFF;
    c[5] = dv > 1000;
    c[6] = int'(s[127:112]) < 100;
    c[7] = longint'(s[207:176]) < 80;
    return c;
  endfunction

  function automatic int tgt_of(input logic [7:0] c);
    if (c[1] || c[3] || c[4]) return 2;
    if (c[0] || c[2] || c[5] || c[6] || c[7]) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    smp_q.delete();
    exp_q.delete();
    edge_no = 0;
    m_state = 0;
    m_up    = 0;
    m_dn    = 0;
    m_cause = '0;
    m_ovf   = 1'b0;
    m_ts    = '0;
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare at negedge.
  task automatic cycle(input logic v, input logic [255:0] s, input logic rdy, input logic clr);
    logic        pop, push, drop;
    logic [47:0] ev;
    smp_t        e;
    int          old_st;
    board_valid   = v;
    board_summary = s;
    evt_ready     = rdy;
    clr_overflow  = clr;
    pop  = (exp_q.size() > 0) && rdy;
    push = 1'b0;
    drop = 1'b0;
    ev   = '0;
    @(posedge clk);
    edge_no++;
    if (smp_q.size() > 0 && smp_q[0].cap == edge_no - 2) begin
      e = smp_q.pop_front();
      old_st = m_state;
      if (e.tgt > m_state) begin
        m_dn = 0;
        if (m_up < DEB) m_up++;
        if (m_up >= DEB) begin m_state = e.tgt; m_up = 0; end
      end else if (e.tgt < m_state) begin
        m_up = 0;
        if (m_dn < DEB) m_dn++;
        if (m_dn >= DEB) begin m_state = m_state - 1; m_dn = 0; end
      end else begin
        m_up = 0;
        m_dn = 0;
      end
      if (m_state != old_st) begin
        push = 1'b1;
        ev = {m_ts, e.cause, 2'b00, 2'(old_st), 2'b00, 2'(m_state)};
      end
    end
    if (smp_q.size() > 0 && smp_q[0].cap == edge_no - 1) m_cause = smp_q[0].cause;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(ev);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_ts++;
    if (v) begin
      e.cap   = edge_no;
      e.cause = cause_of(s);
      e.tgt   = tgt_of(e.cause);
      smp_q.push_back(e);
    end
    @(negedge clk);
    check("health", health_state, 64'(m_state));
    check("cause_now", cause_now, m_cause);
    check("evt_valid", evt_valid, exp_q.size() > 0);
    check("evt_data", evt_data, (exp_q.size() > 0) ? exp_q[0] : 48'h0);
    check("evt_overflow", evt_overflow, m_ovf);
  endtask

  task automatic smp(input logic [255:0] s);
    cycle(1'b1, s, rdy_mode, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, clean(), rdy_mode, 1'b0);
  endtask

  task automatic do_reset();
    board_valid  = 1'b0;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_health", health_state, 0);
    check("rst_cause", cause_now, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_data", evt_data, 0);
    check("rst_overflow", evt_overflow, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- cause vector table ----------------
  typedef struct {
    logic [23:0] p;
    logic [7:0]  g;
    logic [31:0] e;
    logic [7:0]  l;
    logic [31:0] d;
    logic [15:0] a;
    logic [7:0]  exp_cause;
  } vec_t;

  vec_t tbl[20];

  // Random sample of a given severity, values clustered around thresholds.
  function automatic logic [255:0] rand_sample(input int mode);
    logic [23:0] p;
    logic [7:0]  g, l;
    logic [31:0] e, d;
    logic [15:0] a;
    p = 24'($urandom_range(0, 40000));
    g = 8'($urandom_range(0, 1));
    e = 32'($urandom_range(80, 200));
    l = 8'hFF;
    d = 32'($urandom_range(0, 1000));
    a = 16'($urandom_range(100, 5000));
    if (mode == 1) begin
      case ($urandom_range(0, 4))
        0: g = 8'd2;
        1: p = 24'($urandom_range(40001, 60000));
        2: d = 32'($urandom_range(1001, 5000));
        3: a = 16'($urandom_range(0, 99));
        default: e = 32'($urandom_range(0, 79));
      endcase
    end else if (mode == 2) begin
      case ($urandom_range(0, 2))
        0: g = 8'd3;
        1: p = 24'($urandom_range(60001, 24'hFFFFFF));
        default: l = 8'($urandom_range(0, 254));
      endcase
    end
    if ($urandom_range(0, 1) == 1) d = 32'd0 - d;
    return mk(p, g, e, l, d, a);
  endfunction

  // ---------------- main test ----------------
  initial begin
    tbl[0]  = '{24'd1000,  8'd0, 32'd90, 8'hFF, 32'd0,          16'd200, 8'h00};
    tbl[1]  = '{24'd1000,  8'd2, 32'd90, 8'hFF, 32'd0,          16'd200, 8'h01};
    tbl[2]  = '{24'd1000,  8'd3, 32'd90, 8'hFF, 32'd0,          16'd200, 8'h03};
    tbl[3]  = '{24'd1000,  8'd1, 32'd90, 8'hFF, 32'd0,          16'd200, 8'h00};
    tbl[4]  = '{24'd40000, 8'd0, 32'd90, 8'hFF, 32'd0,          16'd200, 8'h00};
    tbl[5]  = '{24'd40001, 8'd0, 32'd90, 8'hFF, 32'd0,          16'd200, 8'h04};
    tbl[6]  = '{24'd60000, 8'd0, 32'd90, 8'hFF, 32'd0,          16'd200, 8'h04};
    tbl[7]  = '{24'd60001, 8'd0, 32'd90, 8'hFF, 32'd0,          16'd200, 8'h0C};
    tbl[8]  = '{24'd1000,  8'd0, 32'd90, 8'h7F, 32'd0,          16'd200, 8'h10};
    tbl[9]  = '{24'd1000,  8'd0, 32'd90, 8'hFF, 32'd1000,       16'd200, 8'h00};
    tbl[10] = '{24'd1000,  8'd0, 32'd90, 8'hFF, 32'd1001,       16'd200, 8'h20};
    tbl[11] = '{24'd1000,  8'd0, 32'd90, 8'hFF, 32'hFFFF_FC17,  16'd200, 8'h20};
    tbl[12] = '{24'd1000,  8'd0, 32'd90, 8'hFF, 32'hFFFF_FC18,  16'd200, 8'h00};
    tbl[13] = '{24'd1000,  8'd0, 32'd90, 8'hFF, 32'h8000_0000,  16'd200, 8'h20};
    tbl[14] = '{24'd1000,  8'd0, 32'd90, 8'hFF, 32'd0,          16'd99,  8'h40};
    tbl[15] = '{24'd1000,  8'd0, 32'd90, 8'hFF, 32'd0,          16'd100, 8'h00};
    tbl[16] = '{24'd1000,  8'd0, 32'd79, 8'hFF, 32'd0,          16'd200, 8'h80};
    tbl[17] = '{24'd1000,  8'd0, 32'd80, 8'hFF, 32'd0,          16'd200, 8'h00};
    tbl[18] = '{24'd60001, 8'd3, 32'd0,  8'h00, 32'd2000,       16'd0,   8'hFF};
    tbl[19] = '{24'd1000,  8'd0, 32'd90, 8'hFF, 32'h7FFF_FFFF,  16'd200, 8'h20};

    model_reset();
    rdy_mode = 1'b1;
    @(negedge clk);
    do_reset();

    // Cause decoding, one sample per vector
    foreach (tbl[i]) begin
      smp(mk(tbl[i].p, tbl[i].g, tbl[i].e, tbl[i].l, tbl[i].d, tbl[i].a));
      idle(1);
      check($sformatf("tbl_cause[%0d]", i), cause_now, tbl[i].exp_cause);
    end
    idle(2);

    // grade=2 x3 -> WARN at edge 5, event {ts=4, cause=01, old=0, new=1}
    do_reset();
    rdy_mode = 1'b0;
    for (int i = 0; i < 3; i++) smp(mk(24'd1000, 8'd2, 32'd90, 8'hFF, 32'd0, 16'd200));
    idle(1);
    check("seq1_health_edge4", health_state, 0);
    idle(1);
    check("seq1_health_edge5", health_state, 1);
    check("seq1_evt_valid", evt_valid, 1);
    check("seq1_evt_fields", evt_data[15:0], 16'h0101);
    check("seq1_evt_ts", evt_data[47:16], 32'd4);

    // Broken run: 2 bad, 1 clean, 2 bad -> no transition
    do_reset();
    for (int i = 0; i < 2; i++) smp(mk(24'd1000, 8'd2, 32'd90, 8'hFF, 32'd0, 16'd200));
    smp(clean());
    for (int i = 0; i < 2; i++) smp(mk(24'd1000, 8'd2, 32'd90, 8'hFF, 32'd0, 16'd200));
    idle(3);
    check("seq2_health", health_state, 0);
    check("seq2_no_evt", evt_valid, 0);

    // Lock loss straight to CRIT, then stepwise recovery
    do_reset();
    for (int i = 0; i < 3; i++) smp(mk(24'd1000, 8'd0, 32'd90, 8'h7F, 32'd0, 16'd200));
    idle(2);
    check("seq3_crit", health_state, 2);
    check("seq3_cause", cause_now, 8'h10);
    for (int i = 0; i < 3; i++) smp(clean());
    idle(2);
    check("seq3_warn", health_state, 1);
    for (int i = 0; i < 3; i++) smp(clean());
    idle(2);
    check("seq3_normal", health_state, 0);
    rdy_mode = 1'b1;
    idle(4);
    check("seq3_drained", evt_valid, 0);

    // Gap between samples 2 and 3 keeps consecutiveness
    do_reset();
    rdy_mode = 1'b0;
    for (int i = 0; i < 2; i++) smp(mk(24'd1000, 8'd2, 32'd90, 8'hFF, 32'd0, 16'd200));
    idle(10);
    check("seq4_hold", health_state, 0);
    smp(mk(24'd1000, 8'd2, 32'd90, 8'hFF, 32'd0, 16'd200));
    idle(1);
    check("seq4_before", health_state, 0);
    idle(1);
    check("seq4_after", health_state, 1);

    // Overflow: 5 transitions with no draining
    do_reset();
    rdy_mode = 1'b0;
    for (int i = 0; i < 3; i++) smp(mk(24'd1000, 8'd0, 32'd90, 8'h7F, 32'd0, 16'd200));
    for (int i = 0; i < 6; i++) smp(clean());
    for (int i = 0; i < 3; i++) smp(mk(24'd1000, 8'd0, 32'd90, 8'h7F, 32'd0, 16'd200));
    for (int i = 0; i < 3; i++) smp(clean());
    idle(3);
    check("ovf_set", evt_overflow, 1);
    check("ovf_evt_valid", evt_valid, 1);
    rdy_mode = 1'b1;
    idle(4);
    check("ovf_drained", evt_valid, 0);
    check("ovf_still_set", evt_overflow, 1);
    cycle(1'b0, clean(), 1'b1, 1'b1);
    check("ovf_cleared", evt_overflow, 0);

    // Refill to full, then push on the same edge as a pop
    rdy_mode = 1'b0;
    for (int i = 0; i < 3; i++) smp(clean());
    for (int i = 0; i < 3; i++) smp(mk(24'd1000, 8'd3, 32'd90, 8'hFF, 32'd0, 16'd200));
    for (int i = 0; i < 6; i++) smp(clean());
    idle(2);
    check("full_valid", evt_valid, 1);
    for (int i = 0; i < 3; i++) smp(mk(24'd1000, 8'd3, 32'd90, 8'hFF, 32'd0, 16'd200));
    idle(1);
    cycle(1'b0, clean(), 1'b1, 1'b0);
    check("full_pushpop_no_drop", evt_overflow, 0);
    check("full_pushpop_health", health_state, 2);
    rdy_mode = 1'b1;
    idle(5);

    // Randomized traffic with mid-stream resets
    begin
      int mode, run;
      mode = 0;
      run  = 0;
      for (int i = 0; i < 3000; i++) begin
        if (i == 1000 || i == 2000) do_reset();
        if (run == 0) begin
          mode = $urandom_range(0, 2);
          run  = $urandom_range(1, 6);
        end
        run--;
        cycle(($urandom_range(0, 9) < 8), rand_sample(mode),
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
